// File: rtl/reparam_pkg.sv
// Shared widths, FSM state encoding and the eps sign-magnitude conversion
// used by the reparameterisation sampler.
package reparam_pkg;

    localparam int Q_FRAC = 16;
    localparam int DATA_W = 20;
    localparam int EPS_W  = 21;
    localparam int PROD_W = 25;
    localparam int SUM_W  = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // A negative zero maps onto plain zero.
    function automatic logic signed [EPS_W-1:0] sm_to_tc(input logic [EPS_W-1:0] sm);
        logic signed [EPS_W-1:0] mag;
        mag = {1'b0, sm[EPS_W-2:0]};
        return sm[EPS_W-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/reparam_mul.sv
// Registered sigma*eps multiply, arithmetic shift by Q_FRAC (floor) and
// truncation to PROD_W; kept separate so the multiplier maps cleanly to a DSP.
module reparam_mul
    import reparam_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sigma_i,
    input  logic signed [EPS_W-1:0]  eps_i,
    output logic signed [PROD_W-1:0] prod_o
);

    localparam int FULL_W = DATA_W + EPS_W;

    logic signed [FULL_W-1:0] sigma_ext;
    logic signed [FULL_W-1:0] eps_ext;
    logic signed [FULL_W-1:0] full;
    logic signed [FULL_W-1:0] shifted;
    logic        [PROD_W-1:0] prod_d;
    logic        [PROD_W-1:0] prod_q;
    logic                     prod_hi_unused;

    assign sigma_ext = $signed({{EPS_W{sigma_i[DATA_W-1]}}, sigma_i});
    assign eps_ext   = $signed({{DATA_W{eps_i[EPS_W-1]}}, eps_i});
    assign full      = sigma_ext * eps_ext;
    assign shifted   = full >>> Q_FRAC;
    assign prod_d    = shifted[PROD_W-1:0];

    // Upper bits after the shift are pure sign copies.
    assign prod_hi_unused = ^shifted[FULL_W-1:PROD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = $signed(prod_q);

endmodule

// File: rtl/reparam_sampler.sv
// z = mu + sigma*eps per handshake, streamed out with index/last framing.
// Define REPARAM_SAT_EN to clamp the sum to 20 bits and raise sat_flag; else the sum wraps.
module reparam_sampler
    import reparam_pkg::*;
#(
    parameter  int LATENT_DIM = 4,
    localparam int IDX_W      = $clog2(LATENT_DIM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] mu_in,
    input  logic signed [DATA_W-1:0] sigma_in,
    input  logic        [EPS_W-1:0]  eps_in,
    output logic signed [DATA_W-1:0] z_out,
    output logic                     z_valid,
    input  logic                     z_ready,
    output logic        [IDX_W-1:0]  z_idx,
    output logic                     z_last,
    output logic                     sat_flag
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LATENT_DIM - 1);

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  mu_q, sigma_q;
    logic signed [EPS_W-1:0]   eps_q;
    logic signed [PROD_W-1:0]  prod;
    logic signed [SUM_W-1:0]   sum;
    logic        [DATA_W-1:0]  z_d;
    logic        [DATA_W-1:0]  z_q;
    logic        [IDX_W-1:0]   idx_q;
    logic                      accept;
    logic                      out_hs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     state_d = ADD;
            ADD:     state_d = OUT;
            OUT:     if (z_ready) state_d = in_valid ? MUL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE) | ((state_q == OUT) & z_ready);
    assign z_valid  = (state_q == OUT);
    assign accept   = in_valid & in_ready;
    assign out_hs   = z_valid & z_ready;

    reparam_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .en_i    (state_q == MUL),
        .sigma_i (sigma_q),
        .eps_i   (eps_q),
        .prod_o  (prod)
    );

    assign sum = {{(SUM_W-DATA_W){mu_q[DATA_W-1]}}, mu_q}
               + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef REPARAM_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_W-1)));

    logic ovf_hi, ovf_lo;
    logic sat_q;

    assign ovf_hi = (sum > SAT_MAX);
    assign ovf_lo = (sum < SAT_MIN);

    always_comb begin
        z_d = sum[DATA_W-1:0];
        if (ovf_hi)      z_d = {1'b0, {(DATA_W-1){1'b1}}};
        else if (ovf_lo) z_d = {1'b1, {(DATA_W-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if ((state_q == ADD) && (ovf_hi || ovf_lo)) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic sum_hi_unused;

    assign z_d           = sum[DATA_W-1:0];
    assign sum_hi_unused = ^sum[SUM_W-1:DATA_W];
    assign sat_flag      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mu_q    <= '0;
            sigma_q <= '0;
            eps_q   <= '0;
            z_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mu_q    <= mu_in;
                sigma_q <= sigma_in;
                eps_q   <= sm_to_tc(eps_in);
            end
            if (state_q == ADD) begin
                z_q <= z_d;
            end
            if (out_hs) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    assign z_out  = $signed(z_q);
    assign z_idx  = idx_q;
    assign z_last = z_valid & (idx_q == IDX_LAST);

endmodule

// File: tb/tb_reparam_sampler.sv
// Directed bench for reparam_sampler: arithmetic cases, backpressure,
// vector framing and asynchronous reset abort, all sampled on the falling edge.
module tb_reparam_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] mu_in;
    logic [19:0] sigma_in;
    logic [20:0] eps_in;
    logic [19:0] z_out;
    logic        z_valid;
    logic        z_ready;
    logic [1:0]  z_idx;
    logic        z_last;
    logic        sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reparam_sampler #(.LATENT_DIM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mu_in    (mu_in),
        .sigma_in (sigma_in),
        .eps_in   (eps_in),
        .z_out    (z_out),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .z_idx    (z_idx),
        .z_last   (z_last),
        .sat_flag (sat_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Presents one element (DUT must be ready), then scrambles the inputs and
    // waits for z_valid; lat counts falling edges after the accept cycle.
    task automatic xfer(input logic [19:0] mu, input logic [19:0] sg,
                        input logic [20:0] ep, output int lat);
        mu_in    = mu;
        sigma_in = sg;
        eps_in   = ep;
        in_valid = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                mu_in    = 20'($urandom);
                sigma_in = 20'($urandom);
                eps_in   = 21'($urandom);
            end
        end while (!z_valid && lat < 20);
    endtask

    task automatic run(input string tag, input logic [19:0] mu, input logic [19:0] sg,
                       input logic [20:0] ep, input logic [19:0] exp_z, input logic [1:0] exp_idx);
        int lat;
        xfer(mu, sg, ep, lat);
        check({tag, "_lat"},  lat, 3);
        check({tag, "_z"},    z_out, exp_z);
        check({tag, "_idx"},  z_idx, exp_idx);
        check({tag, "_last"}, z_last, (exp_idx == 2'd3));
    endtask

    initial begin
        int lat;
        int sent, got, cyc, prev_cyc, nvalid;
        logic acc_pending;
        logic exp_sat;

`ifdef REPARAM_SAT_EN
        exp_sat = 1'b1;
`else
        exp_sat = 1'b0;
`endif
        rst      = 1'b1;
        in_valid = 1'b0;
        mu_in    = '0;
        sigma_in = '0;
        eps_in   = '0;
        z_ready  = 1'b1;
        #3;
        check("rst_z",     z_out, 0);
        check("rst_valid", z_valid, 0);
        check("rst_idx",   z_idx, 0);
        check("rst_last",  z_last, 0);
        check("rst_sat",   sat_flag, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("pos_half",  20'h10000, 20'h20000, 21'h008000, 20'h20000, 2'd0);
        run("neg_half",  20'h10000, 20'h20000, 21'h108000, 20'h00000, 2'd1);
        run("neg_zero",  20'h10000, 20'h20000, 21'h100000, 20'h10000, 2'd2);
        run("floor_pos", 20'h00000, 20'h00001, 21'h000E38, 20'h00000, 2'd3);
        run("floor_neg", 20'h00000, 20'h00001, 21'h100E38, 20'hFFFFF, 2'd0);
        check("pre_ovf_sat", sat_flag, 0);
`ifdef REPARAM_SAT_EN
        run("ovf", 20'h7FFFF, 20'h10000, 21'h008000, 20'h7FFFF, 2'd1);
`else
        run("ovf", 20'h7FFFF, 20'h10000, 21'h008000, 20'h87FFF, 2'd1);
`endif
        @(negedge clk);
        check("ovf_sat", sat_flag, exp_sat);

        // Backpressure: hold z_ready low while a new element waits at the input.
        z_ready = 1'b0;
        xfer(20'h10000, 20'h20000, 21'h008000, lat);
        check("bp_lat", lat, 3);
        in_valid = 1'b1;
        mu_in    = 20'h00000;
        sigma_in = 20'h10000;
        eps_in   = 21'h010000;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", in_ready, 0);
            check("bp_valid", z_valid, 1);
            check("bp_z",     z_out, 20'h20000);
            check("bp_idx",   z_idx, 2);
            @(negedge clk);
        end
        z_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        run("bp_next", 20'h00000, 20'h10000, 21'h010000, 20'h10000, 2'd3);
        check("sat_sticky", sat_flag, exp_sat);

        // Framing: nine back-to-back elements, z = mu since sigma = 0.
        sent        = 0;
        got         = 0;
        cyc         = 0;
        prev_cyc    = 0;
        mu_in       = 20'h00000;
        sigma_in    = 20'h00000;
        eps_in      = 21'h01ABCD;
        in_valid    = 1'b1;
        acc_pending = in_ready;
        while (got < 9 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (z_valid) begin
                check("frm_idx",     z_idx, got % 4);
                check("frm_last",    z_last, (got % 4) == 3);
                check("frm_z",       z_out, got << 12);
                check("frm_spacing", cyc - prev_cyc, 3);
                prev_cyc = cyc;
                got++;
            end
            if (acc_pending) begin
                sent++;
                mu_in = 20'(sent << 12);
                if (sent == 9) in_valid = 1'b0;
            end
            acc_pending = in_valid & in_ready;
        end
        check("frm_count", got, 9);

        // Reset abort while the element sits in ADD.
        mu_in    = 20'h30000;
        sigma_in = 20'h00000;
        eps_in   = 21'h000000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_z",     z_out, 0);
        check("abort_valid", z_valid, 0);
        check("abort_idx",   z_idx, 0);
        check("abort_last",  z_last, 0);
        check("abort_sat",   sat_flag, 0);
        @(negedge clk);
        rst    = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            if (z_valid) nvalid++;
            @(negedge clk);
        end
        check("abort_no_valid", nvalid, 0);
        check("abort_ready",    in_ready, 1);
        run("post_rst", 20'h10000, 20'h20000, 21'h008000, 20'h20000, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reparam_sampler.md
# reparam_sampler

- Reparameterisation stage directly downstream of the epsilon PRNG: computes z = mu + sigma·eps for one latent element per handshake.
- Captures the PRNG's `random_out` word only at the input handshake.
- Streams z elements to the decoder with valid/ready flow control, an element index and an end-of-vector marker.
- Sits between the encoder's mu/sigma output and the decoder input in the Level-3 20-bit datapath.

## Interface
- `LATENT_DIM`, default 4: elements per latent vector; minimum 2.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  mu/sigma/eps present.
- `in_ready`  out  1  block can accept.
- `mu_in`  in  20  signed Q4.16, two's complement.
- `sigma_in`  in  20  signed Q4.16, two's complement.
- `eps_in`  in  21  PRNG word, sign-magnitude: bit 20 = sign (1 = negative), [19:0] = magnitude, unsigned Q4.16.
- `z_out`  out  20  signed Q4.16 result.
- `z_valid`  out  1  z_out valid.
- `z_ready`  in  1  downstream accepts.
- `z_idx`  out  $clog2(LATENT_DIM)  element index of z_out.
- `z_last`  out  1  high with z_valid when z_idx == LATENT_DIM-1.
- `sat_flag`  out  1  sticky overflow indicator.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, go to MUL.
  - MUL → ADD unconditionally.
  - ADD → OUT unconditionally.
  - OUT: z_valid=1. If z_ready and in_valid, go to MUL (back-to-back accept). If z_ready only, go to IDLE. Otherwise hold.
- in_ready = (state==IDLE) | (state==OUT & z_ready).
- Accept (in_valid & in_ready) registers mu_in, sigma_in, eps_in.
- Eps conversion: 21-bit two's complement = sign ? −mag : +mag. Magnitude 0 with sign=1 yields 0.
- MUL: 41-bit signed product sigma·eps. Arithmetic shift right 16 (floor, no rounding). Register the low 25 bits.
- ADD: 26-bit sum = sext(mu) + sext(prod). Narrow to 20 bits per Configuration. Register into z_out.
- z_idx:
  - Increments on output handshake (z_valid & z_ready).
  - Wraps LATENT_DIM-1 → 0.
  - z_last is combinational from z_idx and z_valid.
- z_out, z_idx and z_last hold stable while z_valid & !z_ready.
- sat_flag clears only on rst.
- Reset values: z_out=0, z_valid=0, z_idx=0, z_last=0, sat_flag=0, state=IDLE; in_ready=1 after reset.
- rst asserted in any state aborts the in-flight element; no partial output is produced.

## Timing
- Latency: accept edge in cycle 0 → z_valid high in cycle 3.
- Throughput: one element per 3 cycles with z_ready held high.
- No combinational path from in_valid to in_ready. z_ready → in_ready is combinational, through OUT only.
- eps_in, mu_in and sigma_in are ignored outside the accept cycle.

## Configuration
- `REPARAM_SAT_EN` defined:
  - 26-bit sum outside [−524288, 524287] clamps to 0x80000 or 0x7FFFF.
  - sat_flag sets on any clamp.
- Not defined:
  - z_out = sum[19:0] (wrap).
  - sat_flag tied 0.

## Structure
- Package `reparam_pkg` holds:
  - Q_FRAC=16, DATA_W=20, EPS_W=21, PROD_W=25, SUM_W=26.
  - The state enum {IDLE, MUL, ADD, OUT}.
  - A function for sign-magnitude → two's complement.
- One sub-module, `reparam_mul`:
  - Registered sigma·eps multiply, shift and truncate to PROD_W.
  - Keeps the DSP inference isolated.
- FSM, adder, narrowing and index counter stay in the top module.

## Test plan
- Basic, three cases with mu=0x10000 and sigma=0x20000:
  - eps={0,0x08000} → z_out=0x20000, z_valid in cycle 3, z_idx=0.
  - eps={1,0x08000} → 0x00000.
  - eps={1,0x00000} → 0x10000.
- Floor truncation, mu=0 and sigma=0x00001:
  - eps={0,0x00E38} → 0x00000.
  - eps={1,0x00E38} → 0xFFFFF.
- Overflow: mu=0x7FFFF, sigma=0x10000, eps={0,0x08000}.
  - With REPARAM_SAT_EN → 0x7FFFF, sat_flag=1 and stays 1.
  - Without → 0x87FFF, sat_flag=0.
- Backpressure: z_ready low 5 cycles in OUT.
  - z_out, z_idx and z_valid stable; in_ready=0; in_valid not accepted.
  - On z_ready=1, a pending in_valid is accepted in the same cycle.
- Vector framing, LATENT_DIM=4, 9 accepts with z_ready=1:
  - z_idx sequence 0,1,2,3,0,1,2,3,0.
  - z_last high only on 4th and 8th outputs.
  - Spacing exactly 3 cycles.
- Reset mid-operation: rst pulse while in ADD.
  - All outputs 0 immediately (async); no z_valid for the aborted element.
  - in_ready=1 after release; next accept gives z_idx=0.
